// File: rtl/addrreg_bus_sequencer.sv
// Shares one address bus among NUM_REG address registers: round-robin grant, timed
// ASSERT_bar drive, optional post-increment, one-cycle ACK. Option: ADDRSEQ_PC_PRIORITY_EN.
module addrreg_bus_sequencer #(
  parameter int unsigned NUM_REG     = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REG-1:0]         REQ,
  input  logic [NUM_REG-1:0]         REQ_INC,
  output logic [NUM_REG-1:0]         ASSERT_bar,
  output logic [NUM_REG-1:0]         INC,
  output logic [NUM_REG-1:0]         ACK,
  output logic                       MEM_STROBE,
  output logic                       BUSY,
  output logic [$clog2(NUM_REG)-1:0] GRANT_IDX
);

  localparam int unsigned IDX_W = $clog2(NUM_REG);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_INCR,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               inc_l_q, inc_l_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;

  logic [NUM_REG-1:0] assert_bar_d;
  logic [NUM_REG-1:0] inc_d;
  logic [NUM_REG-1:0] ack_d;
  logic               strobe_d;
  logic               busy_d;

  // Arbiter: first requester found searching upward from rr_q+1, wrapping
  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= int'(NUM_REG); k++) begin
      cand = (int'(rr_q) + k) % int'(NUM_REG);
      if (!pick_vld && REQ[IDX_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
`ifdef ADDRSEQ_PC_PRIORITY_EN
    if (REQ[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
`endif
  end

  // Next state, then output decode of the next state so outputs come straight from flops
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    inc_l_d = inc_l_q;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_ADDR;
          gnt_d   = pick_idx;
          inc_l_d = REQ_INC[pick_idx];
          wcnt_d  = CNT_W'(WAIT_STATES);
`ifdef ADDRSEQ_PC_PRIORITY_EN
          if (pick_idx != '0) rr_d = pick_idx;
`else
          rr_d    = pick_idx;
`endif
        end
      end
      S_ADDR: begin
        if (wcnt_q == '0) begin
          state_d = inc_l_q ? S_INCR : S_DONE;
        end else begin
          wcnt_d = wcnt_q - CNT_W'(1);
        end
      end
      S_INCR:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    assert_bar_d = '1;
    inc_d        = '0;
    ack_d        = '0;
    strobe_d     = 1'b0;
    busy_d       = (state_d != S_IDLE);

    unique case (state_d)
      S_ADDR: begin
        assert_bar_d[gnt_d] = 1'b0;
        strobe_d            = (wcnt_d == '0);
      end
      S_INCR:  inc_d[gnt_d] = 1'b1;
      S_DONE:  ack_d[gnt_d] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      rr_q       <= IDX_W'(NUM_REG - 1);
      inc_l_q    <= 1'b0;
      wcnt_q     <= '0;
      ASSERT_bar <= '1;
      INC        <= '0;
      ACK        <= '0;
      MEM_STROBE <= 1'b0;
      BUSY       <= 1'b0;
      GRANT_IDX  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      inc_l_q    <= inc_l_d;
      wcnt_q     <= wcnt_d;
      ASSERT_bar <= assert_bar_d;
      INC        <= inc_d;
      ACK        <= ack_d;
      MEM_STROBE <= strobe_d;
      BUSY       <= busy_d;
      GRANT_IDX  <= gnt_d;
    end
  end

endmodule

// File: tb/tb_addrreg_bus_sequencer.sv
// Scoreboard bench for addrreg_bus_sequencer: a transaction-level arbiter model predicts
// each access; a negedge monitor rebuilds observed accesses and compares on ACK.
module tb_addrreg_bus_sequencer;

  localparam int NR = 4;
  localparam int WS = 1;
  localparam int IW = $clog2(NR);

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NR-1:0] req, req_inc;
  logic [NR-1:0] ab, inc, ack;
  logic          strobe, busy;
  logic [IW-1:0] gidx;

  logic          rst0;
  logic [NR-1:0] req0, req_inc0;
  logic [NR-1:0] ab0, inc0, ack0;
  logic          strobe0, busy0;
  logic [IW-1:0] gidx0;

  addrreg_bus_sequencer #(.NUM_REG(NR), .WAIT_STATES(WS)) u_dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_INC(req_inc),
    .ASSERT_bar(ab), .INC(inc), .ACK(ack),
    .MEM_STROBE(strobe), .BUSY(busy), .GRANT_IDX(gidx)
  );

  addrreg_bus_sequencer #(.NUM_REG(NR), .WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RST(rst0), .REQ(req0), .REQ_INC(req_inc0),
    .ASSERT_bar(ab0), .INC(inc0), .ACK(ack0),
    .MEM_STROBE(strobe0), .BUSY(busy0), .GRANT_IDX(gidx0)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          cyc = 0;
  logic        rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    int idx;
    int inc;
    int grant_cyc;
    int ack_cyc;
  } exp_t;
  exp_t q[$];

  // ---------------- monitor ----------------
  bit            obs_active;
  int            obs_idx, obs_len, obs_grant, strobe_cnt, strobe_cyc, inc_pulses, last_idx;
  int            lows, own;
  logic [NR-1:0] inc_seen;
  exp_t          e;

  function automatic void obs_clear();
    obs_active = 1'b0;
    obs_idx    = -1;
    obs_len    = 0;
    obs_grant  = -1;
    strobe_cnt = 0;
    strobe_cyc = -1;
    inc_pulses = 0;
    inc_seen   = '0;
  endfunction

  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_assert_bar", 32'(ab), 32'({NR{1'b1}}));
      check("rst_inc", 32'(inc), 32'(0));
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_strobe", 32'(strobe), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_grant_idx", 32'(gidx), 32'(0));
      obs_clear();
      last_idx = 0;
    end else begin
      lows = $countones(~ab);
      own  = -1;
      for (int i = 0; i < NR; i++) if (!ab[i]) own = i;
      check("single_bus_owner", 32'(lows <= 1), 32'(1));
      check("assert_inc_exclusive", 32'(lows != 0 && inc != '0), 32'(0));
      check("busy", 32'(busy), 32'(lows != 0 || inc != '0 || ack != '0));
      if (!busy) check("grant_idx_hold", 32'(gidx), 32'(last_idx));
      if (lows != 0) begin
        if (!obs_active) begin
          obs_active = 1'b1;
          obs_idx    = own;
          obs_grant  = cyc;
        end else if (own != obs_idx) begin
          check("bus_owner_stable", 32'(own), 32'(obs_idx));
        end
        obs_len++;
        if (strobe) begin
          strobe_cnt++;
          strobe_cyc = cyc;
        end
      end else if (strobe) begin
        check("strobe_without_bus", 32'(strobe), 32'(0));
      end
      if (inc != '0) inc_pulses++;
      inc_seen |= inc;
      if (ack != '0) begin
        if (q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'(0));
        end else begin
          e = q.pop_front();
          check("ack_onehot", 32'(ack), 32'(1) << e.idx);
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("grant_idx", 32'(gidx), 32'(e.idx));
          check("addr_owner", 32'(obs_idx), 32'(e.idx));
          check("addr_start", 32'(obs_grant), 32'(e.grant_cyc));
          check("addr_len", 32'(obs_len), 32'(WS + 1));
          check("strobe_count", 32'(strobe_cnt), 32'(1));
          check("strobe_cycle", 32'(strobe_cyc), 32'(e.grant_cyc + WS));
          check("inc_pulse", 32'(inc_seen), e.inc != 0 ? (32'(1) << e.idx) : 32'(0));
          check("inc_count", 32'(inc_pulses), 32'(e.inc));
          last_idx = e.idx;
        end
        obs_clear();
      end
    end
  end

  // ---------------- reference model + requesters ----------------
  int            rr_m, free_cyc, cur, cur_ack;
  bit            in_access;
  logic [NR-1:0] hold;

  task automatic decide();
    int g;
    if (cyc >= free_cyc && req != '0) begin
      g = -1;
`ifdef ADDRSEQ_PC_PRIORITY_EN
      if (req[0]) g = 0;
`endif
      for (int k = 1; k <= NR; k++) begin
        if (g < 0 && req[(rr_m + k) % NR]) g = (rr_m + k) % NR;
      end
`ifdef ADDRSEQ_PC_PRIORITY_EN
      if (g != 0) rr_m = g;
`else
      rr_m = g;
`endif
      cur       = g;
      cur_ack   = cyc + 2 + WS + int'(req_inc[g]);
      free_cyc  = cur_ack + 1;
      in_access = 1'b1;
      q.push_back('{idx: g, inc: int'(req_inc[g]), grant_cyc: cyc + 1, ack_cyc: cur_ack});
    end
  endtask

  task automatic tick();
    decide();
    @(negedge clk);
    if (in_access && cyc == cur_ack) begin
      req[cur]  = 1'b0;
      hold[cur] = 1'b1;
      in_access = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    q.delete();
    rr_m      = NR - 1;
    free_cyc  = 0;
    in_access = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (req != '0 || in_access || cyc < free_cyc); i++) tick();
    check("drain_done", 32'(req != '0 || in_access), 32'(0));
    tick();
    check("scoreboard_empty", 32'(q.size()), 32'(0));
  endtask

  bit ws0_done = 1'b0;

  initial begin
    rst = 1'b1; req = '0; req_inc = '0; hold = '0;
    obs_clear();
    last_idx = 0;
    do_reset();

    // single incrementing access by index 0
    req = 4'b0001; req_inc = 4'b0001;
    drain();

    // all four requesting after reset
    do_reset();
    req = 4'b1111; req_inc = 4'b0000;
    drain();

    // reset in the second address cycle of an index-1 access, index 0 pending
    req = 4'b0010; req_inc = 4'b0010;
    tick();
    req[0] = 1'b1;
    tick();
    do_reset();
    drain();

    // requester 3 drops REQ one cycle after its grant
    req = 4'b1000; req_inc = 4'b1000;
    tick();
    tick();
    req[3] = 1'b0;
    drain();

    // index 0 arrives during an index-1 access
    do_reset();
    req = 4'b1110; req_inc = 4'b0101;
    tick();
    req[0] = 1'b1;
    drain();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && !hold[i] && !(in_access && cur == i) && $urandom_range(0, 3) == 0)
          req[i] = 1'b1;
      end
      hold = '0;
      if (in_access && cyc < cur_ack && $urandom_range(0, 7) == 0) req[cur] = 1'b0;
      req_inc = NR'($urandom);
      tick();
    end
    drain();

    for (int i = 0; i < 20 && !ws0_done; i++) @(negedge clk);
    check("ws0_finished", 32'(ws0_done), 32'(1));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // zero-wait-state instance: single non-incrementing access by index 2
  initial begin
    rst0 = 1'b1; req0 = '0; req_inc0 = '0;
    @(negedge clk);
    rst0 = 1'b0;
    req0 = 4'b0100;
    @(negedge clk);
    check("ws0_assert_bar", 32'(ab0), 32'(4'b1011));
    check("ws0_strobe", 32'(strobe0), 32'(1));
    check("ws0_addr_inc", 32'(inc0), 32'(0));
    check("ws0_addr_ack", 32'(ack0), 32'(0));
    @(negedge clk);
    check("ws0_done_bar", 32'(ab0), 32'(4'b1111));
    check("ws0_done_strobe", 32'(strobe0), 32'(0));
    check("ws0_done_inc", 32'(inc0), 32'(0));
    check("ws0_ack", 32'(ack0), 32'(4'b0100));
    check("ws0_grant_idx", 32'(gidx0), 32'(2));
    req0 = '0;
    @(negedge clk);
    check("ws0_idle_busy", 32'(busy0), 32'(0));
    check("ws0_idle_ack", 32'(ack0), 32'(0));
    check("ws0_idle_inc", 32'(inc0), 32'(0));
    ws0_done = 1'b1;
  end

endmodule
